// File: rtl/mips_alu_hilo_sched_pkg.sv
// Shared definitions for the HI/LO multiply/divide issue controller:
// ALU function codes, scheduler state encoding and op-class helpers.
package mips_alu_hilo_sched_pkg;

    localparam int FUNC_W = 4;

    typedef enum logic [FUNC_W-1:0] {
        F_ADD  = 4'd0,
        F_SUB  = 4'd1,
        F_AND  = 4'd2,
        F_OR   = 4'd3,
        F_XOR  = 4'd4,
        F_SLT  = 4'd5,
        F_SLL  = 4'd6,
        F_SRL  = 4'd7,
        F_MULU = 4'd8,
        F_MULS = 4'd9,
        F_DIVU = 4'd10,
        F_DIVS = 4'd11,
        F_MTHI = 4'd12,
        F_MTLO = 4'd13,
        F_MFHI = 4'd14,
        F_MFLO = 4'd15
    } alu_func_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } sched_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_md(input alu_func_t f);
        return (f == F_MULU) || (f == F_MULS) || (f == F_DIVU) || (f == F_DIVS);
    endfunction

    function automatic logic is_div(input alu_func_t f);
        return (f == F_DIVU) || (f == F_DIVS);
    endfunction

    function automatic logic is_mt(input alu_func_t f);
        return (f == F_MTHI) || (f == F_MTLO);
    endfunction

    function automatic logic is_mf(input alu_func_t f);
        return (f == F_MFHI) || (f == F_MFLO);
    endfunction

endpackage

// File: rtl/mips_alu_hilo_sched_lat_cnt.sv
// Loadable down-counter timing the multi-cycle MUL/DIV latency.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val (has priority over dec)
//   load_val    value to load
//   dec         decrement by one
//   value       current count
//   zero        value == 0
module mips_alu_hilo_lat_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/mips_alu_hilo_sched.sv
// Issue controller for the HI/LO multiply/divide path. Accepts one HI/LO-class
// op at a time, times MUL/DIV with a latency counter, generates HI/LO write
// strobes and back-pressures further HI/LO-class ops until writeback.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   issue_valid  op presented by issue stage
//   issue_func   function code of presented op
//   flush        pipeline flush; aborts in-flight MUL/DIV
//   issue_ready  op accepted when issue_valid & issue_ready
//   unit_start   1-cycle pulse, MUL/DIV operands captured
//   unit_func    function of in-flight op
//   unit_abort   1-cycle pulse, in-flight op discarded
//   store_hi     write HI this cycle
//   store_lo     write LO this cycle
//   busy         state != IDLE
//   done         1-cycle pulse with MUL/DIV writeback
module mips_alu_hilo_sched
    import mips_alu_hilo_sched_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = $clog2(max_int(MUL_LAT, DIV_LAT)) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [FUNC_W-1:0] issue_func,
    input  logic              flush,
    output logic              issue_ready,
    output logic              unit_start,
    output logic [FUNC_W-1:0] unit_func,
    output logic              unit_abort,
    output logic              store_hi,
    output logic              store_lo,
    output logic              busy,
    output logic              done
);

    sched_state_t     state, state_nxt;
    alu_func_t        func;
    logic             f_md, f_mt, f_mf, f_hl;
    logic             accept_hl;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val, cnt_value;

    assign func = alu_func_t'(issue_func);
    assign f_md = is_md(func);
    assign f_mt = is_mt(func);
    assign f_mf = is_mf(func);
    assign f_hl = f_md | f_mt | f_mf;

    // Non-HL ops always pass; HL ops only in IDLE and never alongside a flush.
    assign issue_ready = f_hl ? ((state == S_IDLE) && !flush) : 1'b1;
    assign accept_hl   = issue_valid && f_hl && issue_ready;
    assign busy        = (state != S_IDLE);

    // Loading LAT-2 and leaving RUN on zero puts WB exactly LAT cycles after accept.
    assign cnt_load_val = is_div(func) ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            unit_func <= '0;
        end else begin
            state <= state_nxt;
            if (unit_start) begin
                unit_func <= issue_func;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        unit_start = 1'b0;
        unit_abort = 1'b0;
        store_hi   = 1'b0;
        store_lo   = 1'b0;
        done       = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_hl && f_md) begin
                    unit_start = 1'b1;
                    cnt_load   = 1'b1;
                    state_nxt  = S_RUN;
                end else if (accept_hl && f_mt) begin
                    store_hi = (func == F_MTHI);
                    store_lo = (func == F_MTLO);
                end
            end
            S_RUN: begin
                if (flush) begin
                    unit_abort = 1'b1;
                    state_nxt  = S_IDLE;
                end else if (cnt_zero) begin
                    state_nxt = S_WB;
                end else begin
                    cnt_dec = (cnt_value != '0);
                end
            end
            S_WB: begin
                if (flush) begin
                    unit_abort = 1'b1;
                end else begin
                    store_hi = 1'b1;
                    store_lo = 1'b1;
                    done     = 1'b1;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    mips_alu_hilo_lat_cnt #(
        .CNT_W(CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

endmodule
